// File: rtl/maxnet_iterate.sv
// maxnet_iterate -- iterative Maxnet lateral inhibition over four neurons.
//
// Loads four Q16.16 activations, clamps negatives to zero, then repeats the
// Jacobi update x_k <- ReLU(x_k - EPS * sum_{j!=k} x_j) with one shared
// multiplier (one neuron per cycle). Each finished iteration is published
// on x1..x4 with a one-cycle iter_valid pulse. The run stops when the
// downstream check raises conv_valid, or after MAX_ITER iterations.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               load request, honoured only when idle
//   in1..in4            initial activations, signed Q16.16
//   conv_valid          convergence flag, combinational from x1..x4
//   x1..x4              published activations, always >= 0
//   iter_valid          x1..x4 hold a fresh iteration (1-cycle pulse)
//   busy                run in progress (any state except IDLE)
//   done / timeout      end-of-run pulse / run ended by iteration limit
//   iter_count          completed iterations of current/last run

module maxnet_iterate #(
    parameter logic [15:0] EPS      = 16'h2000,
    parameter int unsigned MAX_ITER = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    input  logic        conv_valid,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] x3,
    output logic [31:0] x4,
    output logic        iter_valid,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  iter_count
);

    typedef enum logic [2:0] {IDLE, SUM, UPD, CHK, DONE} state_t;

    state_t             state_q;
    logic [31:0]        w_q [4];
    logic [31:0]        x_q [4];
    logic signed [33:0] s_q;
    logic [1:0]         k_q;
    logic [7:0]         iter_q;
    logic               iter_valid_q, busy_q, done_q, timeout_q;

    // Shared update datapath for neuron k. S stays fixed for the whole
    // pass, so every neuron sees the previous iteration's values.
    logic [31:0]        wk;
    logic signed [33:0] o;
    logic signed [50:0] o_ext, eps_ext, prod;
    logic signed [34:0] p;
    logic signed [35:0] n;
    logic [31:0]        w_new;
    logic [33:0]        s_d;

    always_comb begin
        wk      = w_q[k_q];
        o       = s_q - $signed({2'b00, wk});
        o_ext   = {{17{o[33]}}, o};
        eps_ext = {35'd0, EPS};
        prod    = o_ext * eps_ext;
        // Dropping the low 16 bits of a signed product floors toward -inf.
        p       = prod[50:16];
        n       = $signed({4'd0, wk}) - $signed({p[34], p});
        w_new   = n[35] ? 32'd0 : n[31:0];
        s_d     = {2'b00, w_q[0]} + {2'b00, w_q[1]}
                + {2'b00, w_q[2]} + {2'b00, w_q[3]};
    end

    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'd0 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
            s_q          <= '0;
            k_q          <= '0;
            iter_q       <= '0;
            iter_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            iter_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    w_q[0]    <= relu(in1);
                    w_q[1]    <= relu(in2);
                    w_q[2]    <= relu(in3);
                    w_q[3]    <= relu(in4);
                    iter_q    <= '0;
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b1;
                    state_q   <= SUM;
                end
                SUM: begin
                    s_q     <= $signed(s_d);
                    k_q     <= '0;
                    state_q <= UPD;
                end
                UPD: begin
                    w_q[k_q] <= w_new;
                    k_q      <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        // Publish all four together; neuron 3's new value
                        // is still only on the datapath this cycle.
                        x_q[0]       <= w_q[0];
                        x_q[1]       <= w_q[1];
                        x_q[2]       <= w_q[2];
                        x_q[3]       <= w_new;
                        iter_q       <= iter_q + 8'd1;
                        iter_valid_q <= 1'b1;
                        state_q      <= CHK;
                    end
                end
                CHK: begin
                    if (conv_valid) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (iter_q == 8'(MAX_ITER)) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= SUM;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x1         = x_q[0];
    assign x2         = x_q[1];
    assign x3         = x_q[2];
    assign x4         = x_q[3];
    assign iter_valid = iter_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_iterate.sv
// Bench for maxnet_iterate: directed test-plan cases plus randomized runs
// checked against an arithmetic Maxnet model.

module tb_maxnet_iterate;

    localparam longint EPS_V = 'h2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MAX_ITER = 64)
    logic        start = 1'b0;
    logic [31:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic        conv_valid;
    logic [31:0] x1, x2, x3, x4;
    logic        iter_valid, busy, done, timeout;
    logic [7:0]  iter_count;
    bit          conv_mode = 1'b0;

    // Second instance with MAX_ITER = 2, convergence tied low
    logic        start2 = 1'b0;
    logic [31:0] x1b, x2b, x3b, x4b;
    logic        iter_valid2, busy2, done2, timeout2;
    logic [7:0]  iter_count2;
    int          pulses2 = 0;

    maxnet_iterate #(.EPS(16'h2000), .MAX_ITER(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .conv_valid(conv_valid),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .iter_valid(iter_valid), .busy(busy), .done(done),
        .timeout(timeout), .iter_count(iter_count)
    );

    maxnet_iterate #(.EPS(16'h2000), .MAX_ITER(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .in1(32'h10000), .in2(32'h10000), .in3(32'h10000), .in4(32'h10000),
        .conv_valid(1'b0),
        .x1(x1b), .x2(x2b), .x3(x3b), .x4(x4b),
        .iter_valid(iter_valid2), .busy(busy2), .done(done2),
        .timeout(timeout2), .iter_count(iter_count2)
    );

    // Downstream check: converged when exactly one activation is nonzero.
    always_comb begin
        int c;
        c = 0;
        if (x1 != 0) c++;
        if (x2 != 0) c++;
        if (x3 != 0) c++;
        if (x4 != 0) c++;
        conv_valid = conv_mode && (c == 1);
    end

    always @(negedge clk) if (iter_valid2) pulses2++;

    int vectors = 0;
    int errs    = 0;
    longint mw[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic longint relu_in(input logic [31:0] v);
        return v[31] ? 64'sd0 : longint'(v);
    endfunction

    // One Jacobi Maxnet iteration on the model state.
    function automatic void model_step();
        longint s, o, n;
        longint nw[4];
        s = mw[0] + mw[1] + mw[2] + mw[3];
        for (int k = 0; k < 4; k++) begin
            o = s - mw[k];
            n = mw[k] - ((o * EPS_V) >>> 16);
            nw[k] = (n < 0) ? 0 : n;
        end
        for (int k = 0; k < 4; k++) mw[k] = nw[k];
    endfunction

    function automatic bit model_onehot();
        int c;
        c = 0;
        for (int k = 0; k < 4; k++) if (mw[k] != 0) c++;
        return c == 1;
    endfunction

    // Full run on the main instance, every iteration checked at its
    // exact expected cycle. poke holds start high while busy.
    task automatic run(input logic [31:0] a, b, c, d, input bit mode, input bit poke);
        int  it, gap;
        bit  fin, conv;
        in1 = a; in2 = b; in3 = c; in4 = d;
        conv_mode = mode;
        mw[0] = relu_in(a); mw[1] = relu_in(b); mw[2] = relu_in(c); mw[3] = relu_in(d);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", busy, 1'b1);
        if (!poke) start = 1'b0;
        it = 0; fin = 0; conv = 0; gap = 5;
        while (!fin) begin
            model_step();
            it++;
            repeat (gap) @(posedge clk);
            #1;
            chk("iter_valid", iter_valid, 1'b1);
            chk("x1", x1, mw[0]);
            chk("x2", x2, mw[1]);
            chk("x3", x3, mw[2]);
            chk("x4", x4, mw[3]);
            chk("iter_count", iter_count, it);
            conv = mode && model_onehot();
            fin  = conv || (it == 64);
            gap  = 6;
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", done, 1'b1);
        chk("timeout", timeout, !conv);
        chk("busy_in_done", busy, 1'b1);
        chk("iter_valid_low", iter_valid, 1'b0);
        @(posedge clk); #1;
        chk("done_low", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("x1_hold", x1, mw[0]);
        chk("count_hold", iter_count, it);
    endtask

    initial begin
        logic [31:0] r[4];
        int i;

        // Reset state
        rst = 1'b1; #12;
        chk("rst_x1", x1, 0); chk("rst_x4", x4, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0); chk("rst_iv", iter_valid, 0);
        chk("rst_count", iter_count, 0);
        rst = 1'b0;

        // Worked example: first iteration at exactly 5 edges after start
        in1 = 32'h10000; in2 = 32'h8000; in3 = 32'h4000; in4 = 32'h2000;
        conv_mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ex_iv_early", iter_valid, 1'b0);
        @(posedge clk); #1;
        chk("ex_iv", iter_valid, 1'b1);
        chk("ex_x1", x1, 32'hE400); chk("ex_x2", x2, 32'h5400);
        chk("ex_x3", x3, 32'h0C00); chk("ex_x4", x4, 32'h0000);
        chk("ex_cnt", iter_count, 8'd1);
        conv_mode = 1'b1;
        i = 0;
        while (!done && i < 200) begin
            @(posedge clk); #1; i++;
        end
        chk("ex_done", done, 1'b1);
        chk("ex_timeout", timeout, 1'b0);
        chk("ex_x1_nz", x1 != 0, 1'b1);
        chk("ex_x2", x2, 0); chk("ex_x3", x3, 0); chk("ex_x4", x4, 0);
        @(posedge clk); #1;

        // Directed runs through the model
        run(32'h10000, 32'h8000, 32'h4000, 32'h2000, 1'b1, 1'b0);
        run(32'hFFFF0000, 32'h8000, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("neg_x2", x2, 32'h8000);
        chk("neg_cnt", iter_count, 8'd1);
        run(32'h10000, 32'h8000, 32'h4000, 32'h2000, 1'b1, 1'b1);   // start held while busy
        run(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);

        // Iteration limit on the MAX_ITER=2 instance
        pulses2 = 0;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("lim_iv1", iter_valid2, 1'b1);
        chk("lim_x1", x1b, 32'hA000); chk("lim_x4", x4b, 32'hA000);
        repeat (6) @(posedge clk); #1;
        chk("lim_iv2", iter_valid2, 1'b1);
        chk("lim_x2_it2", x2b, 32'h6400);
        @(posedge clk); #1;
        chk("lim_done", done2, 1'b1);
        chk("lim_timeout", timeout2, 1'b1);
        chk("lim_cnt", iter_count2, 8'd2);
        @(posedge clk); #1;
        chk("lim_busy", busy2, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("lim_pulses", pulses2, 2);

        // Reset during UPD of iteration 3, then a fresh identical run
        in1 = 32'h10000; in2 = 32'h8000; in3 = 32'h4000; in4 = 32'h2000;
        conv_mode = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1; #1;
        chk("mid_rst_x1", x1, 0); chk("mid_rst_x2", x2, 0);
        chk("mid_rst_cnt", iter_count, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_iv", iter_valid, 0);
        #2; rst = 1'b0;
        run(32'h10000, 32'h8000, 32'h4000, 32'h2000, 1'b1, 1'b0);

        // Randomized runs
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 4; k++) begin
                r[k] = $urandom_range(0, 32'h30000);
                if ($urandom_range(0, 5) == 0) r[k] = -r[k];
            end
            run(r[0], r[1], r[2], r[3], ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
